// File: rtl/dbg_pkg.sv
// Shared encodings for the CPU debug port: run-control states, status view codes, sw layout.
package dbg_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned SW_W    = 16;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } dbg_state_e;

    localparam logic [SEL_W-1:0] SEL_RF_MEM  = 3'd0;
    localparam logic [SEL_W-1:0] SEL_PC      = 3'd1;
    localparam logic [SEL_W-1:0] SEL_NPC     = 3'd2;
    localparam logic [SEL_W-1:0] SEL_IR      = 3'd3;
    localparam logic [SEL_W-1:0] SEL_ALU     = 3'd4;
    localparam logic [SEL_W-1:0] SEL_CTRL    = 3'd5;
    localparam logic [SEL_W-1:0] SEL_RETIRED = 3'd6;
    localparam logic [SEL_W-1:0] SEL_STATE   = 3'd7;

    // Field order fixes the sw bit positions, MSB first.
    typedef struct packed {
        logic [SEL_W-1:0]   sel;
        logic               m_rf;
        logic               halted;
        logic [STATE_W-1:0] state;
        logic               pad;
        logic [7:0]         addr;
    } sw_word_t;

endpackage

// File: rtl/dbg_run_ctrl.sv
// Run/step control FSM gating datapath advance; optional PC breakpoint under DBG_BREAKPOINT_EN.
module dbg_run_ctrl
    import dbg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        succ,
    input  logic        step_edg,
`ifdef DBG_BREAKPOINT_EN
    input  logic [31:0] pc,
    input  logic        bp_valid,
    input  logic [31:0] bp_addr,
`endif
    output logic        cpu_en,
    output logic        halted,
    output logic [1:0]  state,
    output logic        run_arm,
    output logic        bp_hit_flag
);

    dbg_state_e state_q;
    dbg_state_e state_d;
    logic       bp_match;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_HALT;
        else      state_q <= state_d;
    end

    // Next state; a breakpoint match suppresses cpu_en in the same cycle.
    always_comb begin
        state_d  = state_q;
        bp_match = 1'b0;
`ifdef DBG_BREAKPOINT_EN
        bp_match = (state_q == ST_RUN) && bp_valid && (pc == bp_addr);
`endif
        cpu_en   = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !bp_match;
        halted   = (state_q == ST_HALT);
        case (state_q)
            ST_HALT: begin
                if (succ && run_arm)  state_d = ST_RUN;
                else if (step_edg)    state_d = ST_STEP;
            end
            ST_STEP: state_d = ST_HALT;
            ST_RUN:  if (!succ || bp_match) state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    assign state = state_q;

`ifdef DBG_BREAKPOINT_EN
    // run_arm blocks auto-resume until succ is released after a breakpoint.
    always_ff @(posedge clk) begin
        if (!rst) begin
            run_arm     <= 1'b1;
            bp_hit_flag <= 1'b0;
        end else begin
            if (!succ)         run_arm <= 1'b1;
            else if (bp_match) run_arm <= 1'b0;
            if (bp_match)
                bp_hit_flag <= 1'b1;
            else if ((state_q == ST_HALT) && (state_d == ST_STEP))
                bp_hit_flag <= 1'b0;
        end
    end
`else
    assign run_arm     = 1'b1;
    assign bp_hit_flag = 1'b0;
`endif

endmodule

// File: rtl/cpu_debug_port.sv
// CPU-side debug responder: run control, retired counter, status/sw views.
// Optional breakpoint support enabled by defining DBG_BREAKPOINT_EN.
module cpu_debug_port
    import dbg_pkg::*;
#(
    parameter int unsigned MEM_AW = 8,
    parameter int unsigned RF_AW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              succ,
    input  logic              step_edg,
    input  logic [2:0]        sel,
    input  logic              m_rf,
    input  logic [15:0]       m_rf_addr,
    input  logic [31:0]       pc,
    input  logic [31:0]       npc,
    input  logic [31:0]       ir,
    input  logic [31:0]       alu_y,
    input  logic [15:0]       ctrl_bus,
    input  logic [31:0]       rf_rdata,
    input  logic [31:0]       mem_rdata,
`ifdef DBG_BREAKPOINT_EN
    input  logic              bp_valid,
    input  logic [31:0]       bp_addr,
`endif
    output logic              cpu_en,
    output logic [RF_AW-1:0]  rf_dbg_addr,
    output logic [MEM_AW-1:0] mem_dbg_addr,
    output logic [31:0]       status,
    output logic [15:0]       sw,
    output logic              halted
);

    logic [1:0]        state;
    logic              run_arm;
    logic              bp_hit_flag;
    logic [WORD_W-1:0] retired;
    logic [WORD_W-1:0] status_d;
    sw_word_t          sw_d;
    logic              unused_addr_hi;

    dbg_run_ctrl u_run_ctrl (
        .clk         (clk),
        .rst         (rst),
        .succ        (succ),
        .step_edg    (step_edg),
`ifdef DBG_BREAKPOINT_EN
        .pc          (pc),
        .bp_valid    (bp_valid),
        .bp_addr     (bp_addr),
`endif
        .cpu_en      (cpu_en),
        .halted      (halted),
        .state       (state),
        .run_arm     (run_arm),
        .bp_hit_flag (bp_hit_flag)
    );

    assign rf_dbg_addr    = m_rf_addr[RF_AW-1:0];
    assign mem_dbg_addr   = m_rf_addr[MEM_AW-1:0];
    assign unused_addr_hi = ^m_rf_addr[15:8];

    always_ff @(posedge clk) begin
        if (!rst)        retired <= '0;
        else if (cpu_en) retired <= retired + 32'd1;
    end

    always_comb begin
        status_d = '0;
        case (sel)
            SEL_RF_MEM:  status_d = m_rf ? mem_rdata : rf_rdata;
            SEL_PC:      status_d = pc;
            SEL_NPC:     status_d = npc;
            SEL_IR:      status_d = ir;
            SEL_ALU:     status_d = alu_y;
            SEL_CTRL:    status_d = {16'h0, ctrl_bus};
            SEL_RETIRED: status_d = retired;
            SEL_STATE:   status_d = {28'h0, bp_hit_flag, run_arm, state};
            default:     status_d = '0;
        endcase
        sw_d        = '0;
        sw_d.sel    = sel;
        sw_d.m_rf   = m_rf;
        sw_d.halted = halted;
        sw_d.state  = state;
        sw_d.pad    = 1'b0;
        sw_d.addr   = m_rf_addr[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            status <= '0;
            sw     <= '0;
        end else begin
            status <= status_d;
            sw     <= SW_W'(sw_d);
        end
    end

endmodule

// File: tb/tb_cpu_debug_port.sv
// Directed self-checking bench for cpu_debug_port (breakpoint scenario when DBG_BREAKPOINT_EN is defined).
module tb_cpu_debug_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        succ;
    logic        step_edg;
    logic [2:0]  sel;
    logic        m_rf;
    logic [15:0] m_rf_addr;
    logic [31:0] pc, npc, ir, alu_y;
    logic [15:0] ctrl_bus;
    logic [31:0] rf_rdata, mem_rdata;
    logic        cpu_en;
    logic [4:0]  rf_dbg_addr;
    logic [7:0]  mem_dbg_addr;
    logic [31:0] status;
    logic [15:0] sw;
    logic        halted;
`ifdef DBG_BREAKPOINT_EN
    logic        bp_valid;
    logic [31:0] bp_addr;
`endif

    int checks   = 0;
    int failures = 0;

    cpu_debug_port #(.MEM_AW(8), .RF_AW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .succ         (succ),
        .step_edg     (step_edg),
        .sel          (sel),
        .m_rf         (m_rf),
        .m_rf_addr    (m_rf_addr),
        .pc           (pc),
        .npc          (npc),
        .ir           (ir),
        .alu_y        (alu_y),
        .ctrl_bus     (ctrl_bus),
        .rf_rdata     (rf_rdata),
        .mem_rdata    (mem_rdata),
`ifdef DBG_BREAKPOINT_EN
        .bp_valid     (bp_valid),
        .bp_addr      (bp_addr),
`endif
        .cpu_en       (cpu_en),
        .rf_dbg_addr  (rf_dbg_addr),
        .mem_dbg_addr (mem_dbg_addr),
        .status       (status),
        .sw           (sw),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; succ = 1'b0; step_edg = 1'b0; sel = 3'd0; m_rf = 1'b0;
        m_rf_addr = 16'h0; pc = 32'h0; npc = 32'h0; ir = 32'h0; alu_y = 32'h0;
        ctrl_bus = 16'h0; rf_rdata = 32'h0; mem_rdata = 32'h0;
`ifdef DBG_BREAKPOINT_EN
        bp_valid = 1'b0; bp_addr = 32'h0;
`endif
        tick(); tick();
        checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL reset_cpu_en got=%b exp=0", cpu_en); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL reset_halted got=%b exp=1", halted); end
        checks++; if (status !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", status); end
        checks++; if (sw !== 16'h0) begin failures++; $display("FAIL reset_sw got=%h exp=0", sw); end
        rst = 1'b1;
        tick();
        checks++; if (cpu_en !== 1'b0 || halted !== 1'b1) begin failures++; $display("FAIL release_idle got cpu_en=%b halted=%b exp 0/1", cpu_en, halted); end
        checks++; if (status !== 32'h0) begin failures++; $display("FAIL release_status got=%h exp=0", status); end
    endtask

    task automatic test_step();
        sel = 3'd6;
        step_edg = 1'b1;
        tick();
        step_edg = 1'b0;
        checks++; if (cpu_en !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL step_active got cpu_en=%b halted=%b exp 1/0", cpu_en, halted); end
        tick();
        checks++; if (cpu_en !== 1'b0 || halted !== 1'b1) begin failures++; $display("FAIL step_back_halt got cpu_en=%b halted=%b exp 0/1", cpu_en, halted); end
        tick();
        checks++; if (status !== 32'd1) begin failures++; $display("FAIL step_retired got=%0d exp=1", status); end
        checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL step_single got cpu_en=%b exp=0", cpu_en); end
    endtask

    task automatic test_run();
        succ = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL run_cycle%0d got cpu_en=%b exp=1", i, cpu_en); end
            if (i == 4) begin
                checks++; if (sw !== 16'hC200) begin failures++; $display("FAIL run_sw got=%h exp=c200", sw); end
            end
            if (i == 9) succ = 1'b0;
        end
        tick();
        checks++; if (cpu_en !== 1'b0 || halted !== 1'b1) begin failures++; $display("FAIL run_stop got cpu_en=%b halted=%b exp 0/1", cpu_en, halted); end
        tick();
        checks++; if (status !== 32'd11) begin failures++; $display("FAIL run_retired got=%0d exp=11", status); end
    endtask

    task automatic test_back_to_back();
        succ = 1'b1; step_edg = 1'b1;
        tick();
        step_edg = 1'b0;
        checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL simul_c0 got cpu_en=%b exp=1", cpu_en); end
        tick();
        checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL simul_c1 got cpu_en=%b exp=1", cpu_en); end
        tick();
        succ = 1'b0;
        checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL simul_c2 got cpu_en=%b exp=1", cpu_en); end
        tick();
        checks++; if (cpu_en !== 1'b0 || halted !== 1'b1) begin failures++; $display("FAIL simul_stop got cpu_en=%b halted=%b exp 0/1", cpu_en, halted); end
        tick();
        checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL simul_no_step got cpu_en=%b exp=0", cpu_en); end
        checks++; if (status !== 32'd14) begin failures++; $display("FAIL simul_retired got=%0d exp=14", status); end
    endtask

    task automatic test_views();
        logic [31:0] exp_v;
        sel = 3'd0; m_rf = 1'b1; m_rf_addr = 16'h0123; mem_rdata = 32'hDEADBEEF; rf_rdata = 32'h12345678;
        #1;
        checks++; if (mem_dbg_addr !== 8'h23) begin failures++; $display("FAIL mem_addr got=%h exp=23", mem_dbg_addr); end
        checks++; if (rf_dbg_addr !== 5'h03) begin failures++; $display("FAIL rf_addr got=%h exp=03", rf_dbg_addr); end
        tick();
        checks++; if (status !== 32'hDEADBEEF) begin failures++; $display("FAIL view_mem got=%h exp=deadbeef", status); end
        m_rf = 1'b0;
        tick();
        checks++; if (status !== 32'h12345678) begin failures++; $display("FAIL view_rf got=%h exp=12345678", status); end
        pc = 32'h100; npc = 32'h104; ir = 32'hABCD1234; alu_y = 32'h55AA; ctrl_bus = 16'hBEEF;
        for (int s = 1; s < 8; s++) begin
            sel = 3'(s);
            case (s)
                1: exp_v = 32'h100;
                2: exp_v = 32'h104;
                3: exp_v = 32'hABCD1234;
                4: exp_v = 32'h55AA;
                5: exp_v = 32'h0000BEEF;
                6: exp_v = 32'd14;
                default: exp_v = 32'h4;
            endcase
            tick();
            checks++; if (status !== exp_v) begin failures++; $display("FAIL view_sel%0d got=%h exp=%h", s, status, exp_v); end
        end
        checks++; if (sw !== 16'hE823) begin failures++; $display("FAIL halt_sw got=%h exp=e823", sw); end
    endtask

    task automatic test_reset_mid_run();
        sel = 3'd6; m_rf_addr = 16'h0;
        succ = 1'b1;
        tick(); tick();
        checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL midrst_run got cpu_en=%b exp=1", cpu_en); end
        rst = 1'b0;
        tick();
        checks++; if (cpu_en !== 1'b0 || halted !== 1'b1) begin failures++; $display("FAIL midrst_stop got cpu_en=%b halted=%b exp 0/1", cpu_en, halted); end
        checks++; if (status !== 32'h0 || sw !== 16'h0) begin failures++; $display("FAIL midrst_regs got status=%h sw=%h exp 0/0", status, sw); end
        rst = 1'b1; succ = 1'b0;
        tick(); tick();
        checks++; if (status !== 32'h0) begin failures++; $display("FAIL midrst_retired got=%0d exp=0", status); end
    endtask

`ifdef DBG_BREAKPOINT_EN
    task automatic test_breakpoint();
        sel = 3'd7; pc = 32'h0; bp_addr = 32'h0000000C; bp_valid = 1'b1;
        succ = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL bp_run%0d got cpu_en=%b exp=1", i, cpu_en); end
            pc = pc + 32'd4;
        end
        #1;
        checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL bp_gate got cpu_en=%b exp=0", cpu_en); end
        tick();
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL bp_halt got halted=%b exp=1", halted); end
        tick();
        checks++; if (status !== 32'h8) begin failures++; $display("FAIL bp_status got=%h exp=8", status); end
        tick();
        checks++; if (halted !== 1'b1 || cpu_en !== 1'b0) begin failures++; $display("FAIL bp_hold got halted=%b cpu_en=%b exp 1/0", halted, cpu_en); end
        succ = 1'b0;
        tick();
        step_edg = 1'b1;
        tick();
        step_edg = 1'b0;
        checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL bp_step got cpu_en=%b exp=1", cpu_en); end
        pc = 32'h10;
        tick();
        checks++; if (cpu_en !== 1'b0 || halted !== 1'b1) begin failures++; $display("FAIL bp_step_done got cpu_en=%b halted=%b exp 0/1", cpu_en, halted); end
        tick();
        checks++; if (status !== 32'h4) begin failures++; $display("FAIL bp_clear got=%h exp=4", status); end
    endtask
`endif

    initial begin
        test_reset();
        test_step();
        test_run();
        test_back_to_back();
        test_views();
        test_reset_mid_run();
`ifdef DBG_BREAKPOINT_EN
        test_breakpoint();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
